// File: rtl/vga_test_pattern.sv
// VGA test pattern generator: counts pixels from incoming syncs, draws one of
// several fixed patterns, and re-times the syncs so they match the video.
// Optional build macro VGA_TP_SCROLL_EN adds a per-frame scrolling bar pattern (7).
module vga_test_pattern #(
    parameter int SUB_PIXEL_WIDTH = 3,
    parameter int TOTAL_COLS      = 800,
    parameter int TOTAL_ROWS      = 525,
    parameter int ACTIVE_COLS     = 640,
    parameter int ACTIVE_ROWS     = 480
) (
    input  logic                       i_clk,
    input  logic                       i_reset,
    input  logic                       i_hsync,
    input  logic                       i_vsync,
    input  logic [3:0]                 i_pattern,
    output logic                       o_hsync,
    output logic                       o_vsync,
    output logic [SUB_PIXEL_WIDTH-1:0] o_red_video,
    output logic [SUB_PIXEL_WIDTH-1:0] o_grn_video,
    output logic [SUB_PIXEL_WIDTH-1:0] o_blu_video
);

    localparam int COL_W = $clog2(TOTAL_COLS);
    localparam int ROW_W = $clog2(TOTAL_ROWS);
    localparam int BAR_W = ACTIVE_COLS / 8;

    localparam logic [COL_W-1:0] COL_LAST   = COL_W'(TOTAL_COLS - 1);
    localparam logic [ROW_W-1:0] ROW_LAST   = ROW_W'(TOTAL_ROWS - 1);
    localparam logic [COL_W-1:0] A_COLS     = COL_W'(ACTIVE_COLS);
    localparam logic [ROW_W-1:0] A_ROWS     = ROW_W'(ACTIVE_ROWS);
    localparam logic [COL_W-1:0] COL_EDGE_R = COL_W'(ACTIVE_COLS - 3);
    localparam logic [ROW_W-1:0] ROW_EDGE_B = ROW_W'(ACTIVE_ROWS - 3);
    localparam logic [COL_W-1:0] COL_TWO    = COL_W'(2);
    localparam logic [ROW_W-1:0] ROW_TWO    = ROW_W'(2);
    localparam logic [SUB_PIXEL_WIDTH-1:0] MAX = '1;

    logic             vsync_q;
    logic             frame_start;
    logic [COL_W-1:0] col;
    logic [ROW_W-1:0] row;
    logic             hsync_s1;
    logic             vsync_s1;
    logic [3:0]       active_pattern;

    assign frame_start = i_vsync & ~vsync_q;

    // Stage 1: the counters themselves plus the syncs captured on the same edge,
    // so col/row always name the pixel whose syncs sit in hsync_s1/vsync_s1.
    always_ff @(posedge i_clk) begin
        if (!i_reset) begin
            vsync_q        <= 1'b0;
            hsync_s1       <= 1'b0;
            vsync_s1       <= 1'b0;
            col            <= '0;
            row            <= '0;
            active_pattern <= 4'd0;
        end else begin
            vsync_q  <= i_vsync;
            hsync_s1 <= i_hsync;
            vsync_s1 <= i_vsync;
            if (frame_start) begin
                col            <= '0;
                row            <= '0;
                active_pattern <= i_pattern;
            end else if (col == COL_LAST) begin
                col <= '0;
                row <= (row == ROW_LAST) ? '0 : row + ROW_W'(1);
            end else begin
                col <= col + COL_W'(1);
            end
        end
    end

    // Bar number 0..7 for a column: counts how many bar boundaries lie at or below x.
    function automatic logic [2:0] bar_index(input logic [COL_W:0] x);
        logic [2:0] idx;
        idx = 3'd0;
        for (int k = 1; k < 8; k++) begin
            if (x >= (COL_W+1)'(k * BAR_W)) begin
                idx = idx + 3'd1;
            end
        end
        return idx;
    endfunction

`ifdef VGA_TP_SCROLL_EN
    localparam logic [9:0]     FRAME_LAST = 10'(ACTIVE_COLS - 1);
    localparam logic [COL_W:0] A_COLS_X   = (COL_W+1)'(ACTIVE_COLS);

    logic [9:0]     frame_cnt;
    logic [COL_W:0] shift_sum;
    logic [COL_W:0] shift_col;
    logic [2:0]     scroll_bar;

    always_ff @(posedge i_clk) begin
        if (!i_reset) begin
            frame_cnt <= 10'd0;
        end else if (frame_start) begin
            frame_cnt <= (frame_cnt == FRAME_LAST) ? 10'd0 : frame_cnt + 10'd1;
        end
    end

    // Both operands are below ACTIVE_COLS inside the visible area, so one
    // conditional subtract is enough for the modulo.
    assign shift_sum  = {1'b0, col} + (COL_W+1)'(frame_cnt);
    assign shift_col  = (shift_sum >= A_COLS_X) ? shift_sum - A_COLS_X : shift_sum;
    assign scroll_bar = bar_index(shift_col);
`endif

    logic                       in_active;
    logic                       on_border;
    logic [2:0]                 bar;
    logic [SUB_PIXEL_WIDTH-1:0] red_d;
    logic [SUB_PIXEL_WIDTH-1:0] grn_d;
    logic [SUB_PIXEL_WIDTH-1:0] blu_d;

    assign in_active = (col < A_COLS) && (row < A_ROWS);
    assign on_border = (col < COL_TWO) || (col > COL_EDGE_R) ||
                       (row < ROW_TWO) || (row > ROW_EDGE_B);
    assign bar       = bar_index({1'b0, col});

    always_comb begin
        red_d = '0;
        grn_d = '0;
        blu_d = '0;
        case (active_pattern)
            4'd1: red_d = MAX;
            4'd2: grn_d = MAX;
            4'd3: blu_d = MAX;
            4'd4: begin
                if (col[5] ^ row[5]) begin
                    red_d = MAX;
                    grn_d = MAX;
                    blu_d = MAX;
                end
            end
            4'd5: begin
                red_d = bar[2] ? MAX : '0;
                grn_d = bar[1] ? MAX : '0;
                blu_d = bar[0] ? MAX : '0;
            end
            4'd6: begin
                if (on_border) begin
                    red_d = MAX;
                    grn_d = MAX;
                    blu_d = MAX;
                end
            end
`ifdef VGA_TP_SCROLL_EN
            4'd7: begin
                red_d = scroll_bar[2] ? MAX : '0;
                grn_d = scroll_bar[1] ? MAX : '0;
                blu_d = scroll_bar[0] ? MAX : '0;
            end
`endif
            default: begin
                red_d = '0;
                grn_d = '0;
                blu_d = '0;
            end
        endcase
        if (!in_active) begin
            red_d = '0;
            grn_d = '0;
            blu_d = '0;
        end
    end

    // Stage 2: colours for the stage-1 pixel, with that pixel's syncs.
    always_ff @(posedge i_clk) begin
        if (!i_reset) begin
            o_hsync     <= 1'b0;
            o_vsync     <= 1'b0;
            o_red_video <= '0;
            o_grn_video <= '0;
            o_blu_video <= '0;
        end else begin
            o_hsync     <= hsync_s1;
            o_vsync     <= vsync_s1;
            o_red_video <= red_d;
            o_grn_video <= grn_d;
            o_blu_video <= blu_d;
        end
    end

endmodule

// File: tb/tb_vga_test_pattern.sv
// Directed bench for vga_test_pattern on a reduced 72x44 (64x40 visible) raster.
module tb_vga_test_pattern;

    localparam int SPW = 3;
    localparam int TC  = 72;
    localparam int TR  = 44;
    localparam int AC  = 64;
    localparam int AR  = 40;

    localparam logic [8:0] BLK = 9'h000;
    localparam logic [8:0] RED = 9'h1C0;
    localparam logic [8:0] GRN = 9'h038;
    localparam logic [8:0] BLU = 9'h007;
    localparam logic [8:0] CYN = 9'h03F;
    localparam logic [8:0] WHT = 9'h1FF;

    logic           clk = 1'b0;
    logic           reset_n;
    logic           hsync_in;
    logic           vsync_in;
    logic [3:0]     pattern;
    logic           hsync_out;
    logic           vsync_out;
    logic [SPW-1:0] red;
    logic [SPW-1:0] grn;
    logic [SPW-1:0] blu;

    int errors = 0;
    int checks = 0;
    int cur_h = 0;
    int cur_v = 0;
    int d1_h = -1;
    int d1_v = -1;
    int d2_h = -1;
    int d2_v = -1;

    always #5 clk = ~clk;

    vga_test_pattern #(
        .SUB_PIXEL_WIDTH(SPW),
        .TOTAL_COLS     (TC),
        .TOTAL_ROWS     (TR),
        .ACTIVE_COLS    (AC),
        .ACTIVE_ROWS    (AR)
    ) dut (
        .i_clk      (clk),
        .i_reset    (reset_n),
        .i_hsync    (hsync_in),
        .i_vsync    (vsync_in),
        .i_pattern  (pattern),
        .o_hsync    (hsync_out),
        .o_vsync    (vsync_out),
        .o_red_video(red),
        .o_grn_video(grn),
        .o_blu_video(blu)
    );

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        checks++;
        if (got !== exp) begin
            errors++;
            $display("FAIL %s got=%0h expected=%0h", tag, got, exp);
        end
    endtask

    task automatic drive();
        hsync_in = (cur_h < AC);
        vsync_in = (cur_v < AR);
    endtask

    // One pixel clock: afterwards the outputs describe pixel (d2_h, d2_v).
    task automatic step();
        @(posedge clk);
        #1;
        d2_h = d1_h;
        d2_v = d1_v;
        d1_h = cur_h;
        d1_v = cur_v;
        if (cur_h == TC - 1) begin
            cur_h = 0;
            cur_v = (cur_v == TR - 1) ? 0 : cur_v + 1;
        end else begin
            cur_h = cur_h + 1;
        end
        drive();
    endtask

    task automatic wait_out(input int th, input int tv);
        int n;
        n = 0;
        while (!(d2_h == th && d2_v == tv) && n < 10000) begin
            step();
            n++;
        end
        if (n >= 10000) begin
            check($sformatf("timeout_%0d_%0d", th, tv), 32'd0, 32'd1);
        end
    endtask

    task automatic check_px(input string tag, input int th, input int tv, input logic [8:0] exp);
        wait_out(th, tv);
        check($sformatf("%s(%0d,%0d)", tag, th, tv), {23'd0, red, grn, blu}, {23'd0, exp});
    endtask

    initial begin
        reset_n  = 1'b0;
        pattern  = 4'd0;
        hsync_in = 1'b0;
        vsync_in = 1'b0;
        repeat (4) @(posedge clk);
        #1;
        check("reset_rgb", {23'd0, red, grn, blu}, 32'd0);
        check("reset_hsync", {31'd0, hsync_out}, 32'd0);
        check("reset_vsync", {31'd0, vsync_out}, 32'd0);

        // Release with the raster at (0,0): the next edge is the first frame start.
        pattern = 4'd1;
        reset_n = 1'b1;
        drive();

        check_px("p1_red", 0, 0, RED);
        check("p1_hsync_first", {31'd0, hsync_out}, 32'd1);
        check("p1_vsync_first", {31'd0, vsync_out}, 32'd1);
        check_px("p1_red", 63, 0, RED);
        check("p1_hsync_last", {31'd0, hsync_out}, 32'd1);
        check_px("p1_hblank", 64, 0, BLK);
        check("p1_hsync_blank", {31'd0, hsync_out}, 32'd0);
        check_px("p1_red", 63, 39, RED);
        check_px("p1_vblank", 0, 40, BLK);
        check("p1_vsync_blank", {31'd0, vsync_out}, 32'd0);
        wait_out(0, 41);
        pattern = 4'd5;

        check_px("p5_bar", 7, 3, BLK);
        check_px("p5_bar", 8, 3, BLU);
        check_px("p5_bar", 15, 3, BLU);
        check_px("p5_bar", 16, 3, GRN);
        check_px("p5_bar", 24, 3, CYN);
        check_px("p5_bar", 32, 3, RED);
        check_px("p5_bar", 63, 3, WHT);
        check_px("p5_blank", 64, 3, BLK);
        wait_out(0, 41);
        pattern = 4'd4;

        check_px("p4_chk", 31, 0, BLK);
        check_px("p4_chk", 32, 0, WHT);
        check_px("p4_chk", 0, 32, WHT);
        check_px("p4_chk", 32, 32, BLK);
        wait_out(0, 41);
        pattern = 4'd6;

        check_px("p6_border", 0, 0, WHT);
        check_px("p6_inner", 2, 2, BLK);
        check_px("p6_border", 1, 5, WHT);
        check_px("p6_border", 62, 20, WHT);
        check_px("p6_inner", 61, 37, BLK);
        check_px("p6_border", 30, 39, WHT);
        wait_out(0, 41);
        pattern = 4'd1;

        // A mid-frame request must wait for the next frame start.
        check_px("sw_before", 10, 5, RED);
        wait_out(0, 20);
        pattern = 4'd2;
        check_px("sw_held", 10, 30, RED);
        check_px("sw_next", 10, 5, GRN);
        wait_out(0, 41);
        pattern = 4'd7;

        check_px("p7_black", 8, 3, BLK);
        check_px("p7_black", 63, 3, BLK);
        wait_out(0, 41);
        pattern = 4'd3;

        check_px("p3_blue", 20, 10, BLU);

        reset_n = 1'b0;
        @(posedge clk);
        #1;
        check("midreset_rgb", {23'd0, red, grn, blu}, 32'd0);
        check("midreset_hsync", {31'd0, hsync_out}, 32'd0);
        check("midreset_vsync", {31'd0, vsync_out}, 32'd0);

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
